// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3) that streams decimal digits MSD first.
// Latency BIN_W cycles from start to first digit; dig_valid holds its digit stable while dig_ready is low.
module bin2bcd_seq #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4,
  parameter bit LZB    = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BIN_W-1:0] bin_in,
  output logic             busy,
  output logic             dig_valid,
  input  logic             dig_ready,
  output logic [3:0]       dig_out,
  output logic             dig_last,
  output logic             overflow
);

  localparam int BW = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [BIN_W-1:0] MAXV = BIN_W'(10**DIGITS - 1);

  typedef enum logic [1:0] {IDLE, CONVERT, EMIT} state_t;

  state_t           state;
  logic [BIN_W-1:0] bin_r;
  logic [BW-1:0]    bcd;
  logic [BW-1:0]    adj;
  logic [BW-1:0]    bcd_nxt;
  logic [CW-1:0]    cnt;
  logic [IW-1:0]    idx;
  logic             ovf_r;

  // One double-dabble step: correct nibbles >= 5, then shift the next binary bit in.
  always_comb begin
    adj = bcd;
    for (int j = 0; j < DIGITS; j++) begin
      if (adj[4*j +: 4] >= 4'd5) adj[4*j +: 4] = adj[4*j +: 4] + 4'd3;
    end
    bcd_nxt = {adj[BW-2:0], bin_r[BIN_W-1]};
  end

  // Digit i as presented: overflow code, blanked leading zero, or the BCD nibble.
  function automatic logic [3:0] digit_fn(input logic [BW-1:0] b, input int i, input logic ovf);
    logic       allz;
    logic [3:0] d;
    allz = 1'b1;
    d    = 4'h0;
    for (int j = 0; j < DIGITS; j++) begin
      if (j >= i && b[4*j +: 4] != 4'h0) allz = 1'b0;
      if (j == i) d = b[4*j +: 4];
    end
    if (ovf)                         digit_fn = 4'hE;
    else if (LZB && allz && i != 0)  digit_fn = 4'hF;
    else                             digit_fn = d;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bin_r     <= '0;
      bcd       <= '0;
      cnt       <= '0;
      idx       <= '0;
      ovf_r     <= 1'b0;
      busy      <= 1'b0;
      dig_valid <= 1'b0;
      dig_out   <= 4'h0;
      dig_last  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            bin_r <= bin_in;
            bcd   <= '0;
            ovf_r <= (bin_in > MAXV);
            cnt   <= CW'(BIN_W - 1);
            busy  <= 1'b1;
            state <= CONVERT;
          end
        end
        CONVERT: begin
          bcd   <= bcd_nxt;
          bin_r <= {bin_r[BIN_W-2:0], 1'b0};
          if (cnt == '0) begin
            // Final shift: present the MSD of the finished result on this same edge.
            state     <= EMIT;
            idx       <= IW'(DIGITS - 1);
            dig_valid <= 1'b1;
            dig_out   <= digit_fn(bcd_nxt, DIGITS - 1, ovf_r);
            dig_last  <= (DIGITS == 1);
            overflow  <= ovf_r;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        EMIT: begin
          if (dig_ready) begin
            if (dig_last) begin
              state     <= IDLE;
              busy      <= 1'b0;
              dig_valid <= 1'b0;
              dig_last  <= 1'b0;
              overflow  <= 1'b0;
              dig_out   <= 4'h0;
            end else begin
              idx      <= idx - 1'b1;
              dig_out  <= digit_fn(bcd, int'(idx) - 1, ovf_r);
              dig_last <= (idx == IW'(1));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: one instance without and one with leading-zero blanking.
module tb_bin2bcd_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [13:0] bin_in;
  logic        dig_ready;

  logic        busy0, valid0, last0, ovf0;
  logic [3:0]  dout0;
  logic        busy1, valid1, last1, ovf1;
  logic [3:0]  dout1;

  int total;
  int bad;

  // Digits captured by collect(): packed MSD-first, with per-digit last/overflow bits.
  logic [31:0] gw;
  logic [7:0]  glast;
  logic [7:0]  govf;
  int          gn;
  bit          gtimeout;

  bin2bcd_seq #(.BIN_W(14), .DIGITS(4), .LZB(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
    .busy(busy0), .dig_valid(valid0), .dig_ready(dig_ready),
    .dig_out(dout0), .dig_last(last0), .overflow(ovf0)
  );

  bin2bcd_seq #(.BIN_W(14), .DIGITS(4), .LZB(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
    .busy(busy1), .dig_valid(valid1), .dig_ready(dig_ready),
    .dig_out(dout1), .dig_last(last1), .overflow(ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [13:0] v);
    start  = 1'b1;
    bin_in = v;
    step();
    start  = 1'b0;
  endtask

  task automatic collect(input bit sel);
    logic v, l, o;
    logic [3:0] d;
    gw = '0; glast = '0; govf = '0; gn = 0; gtimeout = 1'b0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      v = sel ? valid1 : valid0;
      l = sel ? last1  : last0;
      o = sel ? ovf1   : ovf0;
      d = sel ? dout1  : dout0;
      if (v && dig_ready) begin
        gw    = {gw[27:0], d};
        glast = {glast[6:0], l};
        govf  = {govf[6:0], o};
        gn++;
        if (l || gn == 8) begin
          step();
          return;
        end
      end
      step();
    end
    gtimeout = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; bin_in = '0; dig_ready = 1'b1;
    #12;
    total++;
    if ({busy0, valid0, last0, ovf0, dout0} !== 8'h00) begin
      bad++; $display("FAIL reset0 got=%h want=00", {busy0, valid0, last0, ovf0, dout0});
    end
    total++;
    if ({busy1, valid1, last1, ovf1, dout1} !== 8'h00) begin
      bad++; $display("FAIL reset1 got=%h want=00", {busy1, valid1, last1, ovf1, dout1});
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_latency();
    pulse(14'd1234);
    total++;
    if (busy0 !== 1'b1) begin bad++; $display("FAIL lat_busy got=%b want=1", busy0); end
    repeat (13) step();
    total++;
    if (valid0 !== 1'b0) begin bad++; $display("FAIL lat_early got=%b want=0", valid0); end
    step();
    total++;
    if (valid0 !== 1'b1 || dout0 !== 4'd1) begin
      bad++; $display("FAIL lat_first got=%b/%h want=1/1", valid0, dout0);
    end
    collect(1'b0);
    total++;
    if (gtimeout || gn != 4 || gw[15:0] !== 16'h1234 || glast !== 8'h01) begin
      bad++; $display("FAIL lat_digits got n=%0d d=%h last=%b want n=4 d=1234 last=00000001", gn, gw[15:0], glast);
    end
    total++;
    if (busy0 !== 1'b0 || valid0 !== 1'b0) begin
      bad++; $display("FAIL lat_done got busy=%b valid=%b want 0/0", busy0, valid0);
    end
  endtask

  task automatic test_overflow();
    pulse(14'd9999);
    collect(1'b0);
    total++;
    if (gtimeout || gn != 4 || gw[15:0] !== 16'h9999 || govf !== 8'h00) begin
      bad++; $display("FAIL max9999 got n=%0d d=%h ovf=%b want n=4 d=9999 ovf=0", gn, gw[15:0], govf);
    end
    pulse(14'd10000);
    collect(1'b1);
    total++;
    if (gtimeout || gn != 4 || gw[15:0] !== 16'hEEEE || govf !== 8'h0F || glast !== 8'h01) begin
      bad++; $display("FAIL ovf10000 got n=%0d d=%h ovf=%b last=%b want n=4 d=EEEE ovf=00001111 last=00000001", gn, gw[15:0], govf, glast);
    end
  endtask

  task automatic test_lzb();
    pulse(14'd0);
    collect(1'b0);
    total++;
    if (gtimeout || gn != 4 || gw[15:0] !== 16'h0000) begin
      bad++; $display("FAIL zero_nolzb got n=%0d d=%h want n=4 d=0000", gn, gw[15:0]);
    end
    pulse(14'd0);
    collect(1'b1);
    total++;
    if (gtimeout || gn != 4 || gw[15:0] !== 16'hFFF0) begin
      bad++; $display("FAIL zero_lzb got n=%0d d=%h want n=4 d=FFF0", gn, gw[15:0]);
    end
    pulse(14'd705);
    collect(1'b1);
    total++;
    if (gtimeout || gn != 4 || gw[15:0] !== 16'hF705) begin
      bad++; $display("FAIL 705_lzb got n=%0d d=%h want n=4 d=F705", gn, gw[15:0]);
    end
  endtask

  task automatic test_backpressure();
    int waited;
    dig_ready = 1'b0;
    pulse(14'd4821);
    waited = 0;
    while (valid0 !== 1'b1 && waited < 40) begin step(); waited++; end
    total++;
    if (valid0 !== 1'b1 || dout0 !== 4'd4) begin
      bad++; $display("FAIL bp_first got=%b/%h want=1/4", valid0, dout0);
    end
    dig_ready = 1'b1;
    step();
    dig_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (valid0 !== 1'b1 || dout0 !== 4'd8 || last0 !== 1'b0) begin
        bad++; $display("FAIL bp_hold%0d got v=%b d=%h l=%b want v=1 d=8 l=0", i, valid0, dout0, last0);
      end
    end
    dig_ready = 1'b1;
    collect(1'b0);
    total++;
    if (gtimeout || gn != 3 || gw[11:0] !== 12'h821 || glast !== 8'h01) begin
      bad++; $display("FAIL bp_rest got n=%0d d=%h want n=3 d=821", gn, gw[11:0]);
    end
  endtask

  task automatic test_back_to_back();
    pulse(14'd1234);
    repeat (4) step();
    pulse(14'd4321);
    collect(1'b0);
    total++;
    if (gtimeout || gn != 4 || gw[15:0] !== 16'h1234) begin
      bad++; $display("FAIL ignore_start got n=%0d d=%h want n=4 d=1234", gn, gw[15:0]);
    end
    total++;
    if (busy0 !== 1'b0) begin bad++; $display("FAIL ignore_idle got busy=%b want 0", busy0); end
    pulse(14'd4321);
    collect(1'b0);
    total++;
    if (gtimeout || gn != 4 || gw[15:0] !== 16'h4321) begin
      bad++; $display("FAIL next_start got n=%0d d=%h want n=4 d=4321", gn, gw[15:0]);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    pulse(14'd1234);
    repeat (13) step();
    step();
    step();
    step();
    total++;
    if (dout0 !== 4'd3) begin bad++; $display("FAIL mid_pre got=%h want=3", dout0); end
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy0, valid0, last0, ovf0, dout0} !== 8'h00) begin
      bad++; $display("FAIL mid_async got=%h want=00", {busy0, valid0, last0, ovf0, dout0});
    end
    step();
    step();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (valid0 || busy0) seen++;
      step();
    end
    total++;
    if (seen != 0) begin bad++; $display("FAIL mid_quiet got=%0d want=0", seen); end
    pulse(14'd56);
    collect(1'b0);
    total++;
    if (gtimeout || gn != 4 || gw[15:0] !== 16'h0056) begin
      bad++; $display("FAIL mid_restart got n=%0d d=%h want n=4 d=0056", gn, gw[15:0]);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_latency();
    test_overflow();
    test_lzb();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
